// File: rtl/bus_interconnect.sv
// Single-master, N-slave data-bus interconnect: region decode, req/ready handshake,
// access timeout, error response for unmapped/timed-out accesses, saturating error count.
module bus_interconnect #(
  parameter int                N_SLAVES = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                SEL_LSB  = 12,
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       busReq,
  input  logic                       busWe,
  input  logic [ADDR_W-1:0]          busAddr,
  input  logic [DATA_W-1:0]          busWData,
  output logic [DATA_W-1:0]          busRData,
  output logic                       busReady,
  output logic                       busErr,
  output logic [7:0]                 errCount,
  output logic [N_SLAVES-1:0]        sSel,
  output logic                       sWe,
  output logic [SEL_LSB-1:0]         sAddr,
  output logic [DATA_W-1:0]          sWData,
  input  logic [N_SLAVES*DATA_W-1:0] sRData,
  input  logic [N_SLAVES-1:0]        sReady
);

  localparam int HI_W  = ADDR_W - SEL_LSB;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, stateNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic [N_SLAVES-1:0] sSelNext;
  logic                sWeNext;
  logic [SEL_LSB-1:0]  sAddrNext;
  logic [DATA_W-1:0]   sWDataNext;
  logic [DATA_W-1:0]   busRDataNext;
  logic                busReadyNext;
  logic                busErrNext;
  logic [7:0]          errCountNext;

  logic [HI_W-1:0]     reqRegion;
  logic [N_SLAVES-1:0] reqHit;
  logic [DATA_W-1:0]   maskedData [N_SLAVES];
  logic [DATA_W-1:0]   selData;
  logic                finish;
  logic                finishErr;

  assign reqRegion = busAddr[ADDR_W-1:SEL_LSB];

  // Decode and read-data selection both key off the one-hot select, so an
  // unmapped region simply produces an all-zero hit vector.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : gSlave
      assign reqHit[gi]     = (reqRegion == HI_W'(gi));
      assign maskedData[gi] = sSel[gi] ? sRData[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    selData = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      selData = selData | maskedData[i];
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    sSelNext     = sSel;
    sWeNext      = sWe;
    sAddrNext    = sAddr;
    sWDataNext   = sWData;
    busRDataNext = busRData;
    busReadyNext = 1'b0;
    busErrNext   = 1'b0;
    errCountNext = errCount;
    finish       = 1'b0;
    finishErr    = 1'b0;

    case (state)
      IDLE: begin
        if (busReq) begin
          sAddrNext  = busAddr[SEL_LSB-1:0];
          sWDataNext = busWData;
          if (|reqHit) begin
            stateNext = ACCESS;
            sSelNext  = reqHit;
            sWeNext   = busWe;
            cntNext   = '0;
          end else begin
            finish    = 1'b1;
            finishErr = 1'b1;
          end
        end
      end
      ACCESS: begin
        cntNext = cnt + 1'b1;
        // Ready is checked first so a completion on the last allowed cycle is not an error.
        if (|(sReady & sSel)) begin
          finish = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          finishErr = 1'b1;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    if (finish) begin
      stateNext    = RESP;
      busReadyNext = 1'b1;
      busErrNext   = finishErr;
      busRDataNext = finishErr ? ERR_DATA : (sWe ? '0 : selData);
      sSelNext     = '0;
      sWeNext      = 1'b0;
      if (finishErr && errCount != 8'hFF) begin
        errCountNext = errCount + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sSel     <= '0;
      sWe      <= 1'b0;
      sAddr    <= '0;
      sWData   <= '0;
      busRData <= '0;
      busReady <= 1'b0;
      busErr   <= 1'b0;
      errCount <= 8'd0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      sSel     <= sSelNext;
      sWe      <= sWeNext;
      sAddr    <= sAddrNext;
      sWData   <= sWDataNext;
      busRData <= busRDataNext;
      busReady <= busReadyNext;
      busErr   <= busErrNext;
      errCount <= errCountNext;
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Randomised and directed bench for bus_interconnect; expectations come from a
// transaction-level model of latency, response data, error flag and error count.
module tb_bus_interconnect;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         busReq = 1'b0;
  logic         busWe = 1'b0;
  logic [31:0]  busAddr = '0;
  logic [31:0]  busWData = '0;
  logic [31:0]  busRData;
  logic         busReady;
  logic         busErr;
  logic [7:0]   errCount;
  logic [3:0]   sSel;
  logic         sWe;
  logic [11:0]  sAddr;
  logic [31:0]  sWData;
  logic [127:0] sRData = '0;
  logic [3:0]   sReady = '0;

  logic [31:0]  slvData [4];
  int           checks = 0;
  int           errors = 0;
  int           modelErrCnt = 0;

  always #5 clk = ~clk;

  bus_interconnect dut (
    .clk(clk), .reset(reset), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busWData(busWData), .busRData(busRData), .busReady(busReady), .busErr(busErr),
    .errCount(errCount), .sSel(sSel), .sWe(sWe), .sAddr(sAddr), .sWData(sWData),
    .sRData(sRData), .sReady(sReady)
  );

  // Transaction-level expectation: latency in cycles from request, response, select time.
  task automatic model_txn(input logic we, input logic [31:0] addr, input int readyAt,
                           output int expLat, output logic [31:0] expData, output logic expErr,
                           output int expSel, output logic [3:0] expOh);
    int region;
    region = int'(addr >> 12);
    expOh  = (region < 4) ? (4'b0001 << region) : 4'b0000;
    if (region >= 4) begin
      expLat = 1; expErr = 1'b1; expData = ERR_DATA; expSel = 0;
    end else if (readyAt >= 1 && readyAt <= TIMEOUT) begin
      expLat = readyAt + 1; expErr = 1'b0; expData = we ? 32'h0 : slvData[region]; expSel = readyAt;
    end else begin
      expLat = TIMEOUT + 1; expErr = 1'b1; expData = ERR_DATA; expSel = TIMEOUT;
    end
    if (expErr && modelErrCnt < 255) modelErrCnt++;
  endtask

  // Issues one request and plays the slave side; sReady of the target rises in cycle readyAt.
  task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int readyAt, input logic [3:0] noise,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output logic [7:0] ecnt, output int selCycles,
                           output logic [3:0] selSeen, output logic sigOk);
    logic [31:0] hi;
    logic [3:0]  tgt;
    hi  = addr >> 12;
    tgt = (hi < 4) ? (4'b0001 << hi[1:0]) : 4'b0000;
    lat = -1; rdata = '0; err = 1'b0; ecnt = '0; selCycles = 0; selSeen = '0; sigOk = 1'b1;
    @(posedge clk); #1;
    sRData   = {slvData[3], slvData[2], slvData[1], slvData[0]};
    busReq   = 1'b1;
    busWe    = we;
    busAddr  = addr;
    busWData = wdata;
    sReady   = noise & ~tgt;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      busReq   = 1'b0;
      busWe    = 1'($urandom());
      busAddr  = $urandom();
      busWData = $urandom();
      if (sSel != 4'b0000) begin
        selCycles++;
        selSeen = selSeen | sSel;
        if (sWe !== we || sAddr !== addr[11:0] || sWData !== wdata || busReady) sigOk = 1'b0;
      end
      if (busReady) begin
        lat = c; rdata = busRData; err = busErr; ecnt = errCount;
        break;
      end
      sReady = (noise & ~tgt) | ((c == readyAt) ? tgt : 4'b0000);
    end
    sReady = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++; if (sSel !== 4'b0 || sWe !== 1'b0) begin errors++; $display("FAIL reset_sel: sSel=%b sWe=%b required 0", sSel, sWe); end
    checks++; if (sAddr !== 12'h0 || sWData !== 32'h0) begin errors++; $display("FAIL reset_saddr: sAddr=%h sWData=%h required 0", sAddr, sWData); end
    checks++; if (busReady !== 1'b0 || busErr !== 1'b0) begin errors++; $display("FAIL reset_ready: busReady=%b busErr=%b required 0", busReady, busErr); end
    checks++; if (busRData !== 32'h0 || errCount !== 8'h0) begin errors++; $display("FAIL reset_data: busRData=%h errCount=%0d required 0", busRData, errCount); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    modelErrCnt = 0;
    $display("txn reset: outputs cleared");
  endtask

  task automatic test_read_basic();
    int lat, sc, eLat, eSel; logic [31:0] rd, eData; logic er, eErr, ok; logic [7:0] ec; logic [3:0] ss, eOh;
    slvData[1] = 32'h1234_5678;
    model_txn(1'b0, 32'h0000_1004, 1, eLat, eData, eErr, eSel, eOh);
    drive_txn(1'b0, 32'h0000_1004, 32'h0, 1, 4'b0000, lat, rd, er, ec, sc, ss, ok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL read_lat: got %0d required 2", lat); end
    checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++; $display("FAIL read_data: got %h err=%b required 12345678 err=0", rd, er); end
    checks++; if (ss !== 4'b0010 || sc !== 1 || !ok) begin errors++; $display("FAIL read_sel: sel=%b cycles=%0d sigOk=%b required 0010/1/1", ss, sc, ok); end
    $display("txn read 00001004: lat=%0d data=%h err=%b", lat, rd, er);
  endtask

  task automatic test_write_wait();
    int lat, sc, eLat, eSel; logic [31:0] rd, eData; logic er, eErr, ok; logic [7:0] ec; logic [3:0] ss, eOh;
    model_txn(1'b1, 32'h0000_3010, 4, eLat, eData, eErr, eSel, eOh);
    drive_txn(1'b1, 32'h0000_3010, 32'hCAFE_0001, 4, 4'b0000, lat, rd, er, ec, sc, ss, ok);
    checks++; if (lat !== 5 || er !== 1'b0) begin errors++; $display("FAIL write_lat: got %0d err=%b required 5 err=0", lat, er); end
    checks++; if (ss !== 4'b1000 || sc !== 4 || !ok) begin errors++; $display("FAIL write_sel: sel=%b cycles=%0d sigOk=%b required 1000/4/1", ss, sc, ok); end
    $display("txn write 00003010: lat=%0d err=%b", lat, er);
  endtask

  task automatic test_unmapped();
    int lat, sc, eLat, eSel; logic [31:0] rd, eData; logic er, eErr, ok; logic [7:0] ec; logic [3:0] ss, eOh;
    model_txn(1'b0, 32'h0000_4000, 1, eLat, eData, eErr, eSel, eOh);
    drive_txn(1'b0, 32'h0000_4000, 32'h0, 1, 4'b0000, lat, rd, er, ec, sc, ss, ok);
    checks++; if (lat !== 1 || sc !== 0) begin errors++; $display("FAIL unmapped_lat: lat=%0d selCycles=%0d required 1/0", lat, sc); end
    checks++; if (rd !== ERR_DATA || er !== 1'b1) begin errors++; $display("FAIL unmapped_resp: data=%h err=%b required deadbeef/1", rd, er); end
    checks++; if (ec !== 8'(modelErrCnt)) begin errors++; $display("FAIL unmapped_cnt: got %0d required %0d", ec, modelErrCnt); end
    $display("txn read 00004000: lat=%0d data=%h err=%b errCount=%0d", lat, rd, er, ec);
  endtask

  task automatic test_timeout();
    int lat, sc, eLat, eSel; logic [31:0] rd, eData; logic er, eErr, ok; logic [7:0] ec; logic [3:0] ss, eOh;
    model_txn(1'b0, 32'h0000_0020, 0, eLat, eData, eErr, eSel, eOh);
    drive_txn(1'b0, 32'h0000_0020, 32'h0, 0, 4'b1110, lat, rd, er, ec, sc, ss, ok);
    checks++; if (sc !== TIMEOUT || ss !== 4'b0001) begin errors++; $display("FAIL timeout_sel: cycles=%0d sel=%b required 16/0001", sc, ss); end
    checks++; if (lat !== TIMEOUT + 1 || er !== 1'b1 || rd !== ERR_DATA) begin errors++; $display("FAIL timeout_resp: lat=%0d err=%b data=%h required 17/1/deadbeef", lat, er, rd); end
    checks++; if (ec !== 8'(modelErrCnt)) begin errors++; $display("FAIL timeout_cnt: got %0d required %0d", ec, modelErrCnt); end
    $display("txn timeout 00000020: lat=%0d err=%b", lat, er);
    // Ready on the final allowed cycle must complete cleanly.
    model_txn(1'b0, 32'h0000_2000, TIMEOUT, eLat, eData, eErr, eSel, eOh);
    drive_txn(1'b0, 32'h0000_2000, 32'h0, TIMEOUT, 4'b0000, lat, rd, er, ec, sc, ss, ok);
    checks++; if (lat !== eLat || er !== eErr || rd !== eData) begin errors++; $display("FAIL ready_at_limit: lat=%0d err=%b data=%h required %0d/%b/%h", lat, er, rd, eLat, eErr, eData); end
    $display("txn read 00002000 ready@16: lat=%0d err=%b", lat, er);
  endtask

  task automatic test_random();
    int lat, sc, eLat, eSel, ra; logic [31:0] rd, eData, addr, wd; logic er, eErr, ok, we; logic [7:0] ec; logic [3:0] ss, eOh, nz;
    for (int t = 0; t < 30; t++) begin
      for (int s = 0; s < 4; s++) slvData[s] = $urandom();
      addr = {20'($urandom_range(0, 5)), 12'($urandom())};
      wd   = $urandom();
      we   = 1'($urandom());
      ra   = $urandom_range(0, 18);
      nz   = 4'($urandom());
      model_txn(we, addr, ra, eLat, eData, eErr, eSel, eOh);
      drive_txn(we, addr, wd, ra, nz, lat, rd, er, ec, sc, ss, ok);
      checks++; if (lat !== eLat) begin errors++; $display("FAIL rand_lat[%0d]: got %0d required %0d", t, lat, eLat); end
      checks++; if (rd !== eData || er !== eErr) begin errors++; $display("FAIL rand_resp[%0d]: data=%h err=%b required %h/%b", t, rd, er, eData, eErr); end
      checks++; if (ec !== 8'(modelErrCnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d required %0d", t, ec, modelErrCnt); end
      checks++; if (sc !== eSel || ss !== eOh || !ok) begin errors++; $display("FAIL rand_sel[%0d]: cycles=%0d sel=%b sigOk=%b required %0d/%b/1", t, sc, ss, ok, eSel, eOh); end
      $display("txn rand %0d: %s addr=%h ready@%0d lat=%0d data=%h err=%b", t, we ? "wr" : "rd", addr, ra, lat, rd, er);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, sc, eLat, eSel; logic [31:0] rd, eData; logic er, eErr, ok; logic [7:0] ec; logic [3:0] ss, eOh;
    @(posedge clk); #1;
    busReq = 1'b1; busWe = 1'b0; busAddr = 32'h0000_2008; sReady = '0;
    @(posedge clk); #1;
    busReq = 1'b0;
    checks++; if (sSel !== 4'b0100) begin errors++; $display("FAIL midrst_pre: sSel=%b required 0100", sSel); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    modelErrCnt = 0;
    checks++; if (sSel !== 4'b0 || errCount !== 8'h0 || busReady !== 1'b0) begin errors++; $display("FAIL midrst_now: sSel=%b errCount=%0d busReady=%b required 0", sSel, errCount, busReady); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (busReady !== 1'b0 || sSel !== 4'b0) begin errors++; $display("FAIL midrst_after[%0d]: busReady=%b sSel=%b required 0", c, busReady, sSel); end
    end
    slvData[2] = 32'hA5A5_0F0F;
    model_txn(1'b0, 32'h0000_2008, 2, eLat, eData, eErr, eSel, eOh);
    drive_txn(1'b0, 32'h0000_2008, 32'h0, 2, 4'b0000, lat, rd, er, ec, sc, ss, ok);
    checks++; if (lat !== eLat || rd !== eData || er !== eErr) begin errors++; $display("FAIL midrst_next: lat=%0d data=%h err=%b required %0d/%h/%b", lat, rd, er, eLat, eData, eErr); end
    $display("txn reset mid-access then read 00002008: lat=%0d data=%h", lat, rd);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic expReady;
    @(posedge clk); #1;
    busReq = 1'b1; busWe = 1'b0; sReady = '0;
    busAddr = {20'($urandom_range(4, 20'hFFFFF)), 12'($urandom())};
    for (int c = 1; c <= 520; c++) begin
      @(posedge clk); #1;
      busAddr  = {20'($urandom_range(4, 20'hFFFFF)), 12'($urandom())};
      expReady = (c % 2 == 1);
      checks++; if (busReady !== expReady) begin errors++; $display("FAIL b2b_ready[%0d]: got %b required %b", c, busReady, expReady); end
      if (busReady) begin
        pulses++;
        if (modelErrCnt < 255) modelErrCnt++;
        checks++; if (busErr !== 1'b1 || busRData !== ERR_DATA || errCount !== 8'(modelErrCnt)) begin errors++; $display("FAIL b2b_resp[%0d]: err=%b data=%h errCount=%0d required 1/deadbeef/%0d", c, busErr, busRData, errCount, modelErrCnt); end
        $display("txn b2b %0d: err=%b errCount=%0d", pulses, busErr, errCount);
      end
    end
    busReq = 1'b0;
    checks++; if (pulses !== 260 || errCount !== 8'd255) begin errors++; $display("FAIL b2b_total: pulses=%0d errCount=%0d required 260/255", pulses, errCount); end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) slvData[s] = $urandom();
    test_reset();
    test_read_basic();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_random();
    test_reset_mid_access();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
